// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier that borrows the shared ALU.
// Define ALU_MUL_EARLY_EXIT_EN to end RUN once no multiplier bits remain.
`timescale 1ns/1ps
module alu_mul_seq #(
  parameter int Data_Width = 32,
  parameter int Cnt_Width  = $clog2(Data_Width)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Data_Width-1:0] in_a,
  input  logic [Data_Width-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Data_Width-1:0] out_result,
  input  logic                  flush,
  output logic                  busy,
  input  logic [Data_Width-1:0] dp_op1,
  input  logic [Data_Width-1:0] dp_op2,
  input  logic [3:0]            dp_ctrl,
  output logic [Data_Width-1:0] dp_result,
  output logic                  dp_eq,
  output logic                  dp_stall,
  output logic [Data_Width-1:0] alu_op1,
  output logic [Data_Width-1:0] alu_op2,
  output logic [3:0]            alu_ctrl,
  input  logic [Data_Width-1:0] alu_result,
  input  logic                  alu_eq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [Cnt_Width-1:0] LastCnt =
    Cnt_Width'(Data_Width - 1);

  state_t                state;
  state_t                state_nx;
  logic [Data_Width-1:0] acc;
  logic [Data_Width-1:0] mcand;
  logic [Data_Width-1:0] mplier;
  logic [Cnt_Width-1:0]  cnt;
  logic                  last;
  logic                  accept;
  logic                  abort;

  assign accept = (state == IDLE) && in_valid && !flush;
  assign abort  = (state != IDLE) && flush;

  // final RUN iteration detect
  always_comb begin
`ifdef ALU_MUL_EARLY_EXIT_EN
    last = (cnt == LastCnt) || ((mplier >> 1) == '0);
`else
    last = (cnt == LastCnt);
`endif
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state, handshake outputs and ALU ownership mux
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    dp_stall   = 1'b0;
    out_valid  = 1'b0;
    out_result = '0;
    alu_op1    = dp_op1;
    alu_op2    = dp_op2;
    alu_ctrl   = dp_ctrl;
    dp_result  = alu_result;
    dp_eq      = alu_eq;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nx = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        dp_stall  = 1'b1;
        alu_ctrl  = 4'b0000;
        alu_op1   = acc;
        alu_op2   = mplier[0] ? mcand : '0;
        dp_result = '0;
        dp_eq     = 1'b0;
        unique case (1'b1)
          flush:   state_nx = IDLE;
          last:    state_nx = DONE;
          default: state_nx = RUN;
        endcase
      end
      DONE: begin
        busy       = 1'b1;
        dp_stall   = 1'b1;
        out_valid  = 1'b1;
        out_result = acc;
        alu_ctrl   = 4'b0000;
        alu_op1    = acc;
        alu_op2    = '0;
        dp_result  = '0;
        dp_eq      = 1'b0;
        if (flush || out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand, accumulator and iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (abort) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          acc    <= '0;
          mcand  <= in_a;
          mplier <= in_b;
          cnt    <= '0;
        end
        (state == RUN): begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: random and directed multiplies against a product model.
// Bench supplies the shared ALU (add, sub, xor) behind the mux.
`timescale 1ns/1ps
module tb_alu_mul_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         flush = 1'b0;
  logic         busy;
  logic [W-1:0] dp_op1 = '0;
  logic [W-1:0] dp_op2 = '0;
  logic [3:0]   dp_ctrl = '0;
  logic [W-1:0] dp_result;
  logic         dp_eq;
  logic         dp_stall;
  logic [W-1:0] alu_op1;
  logic [W-1:0] alu_op2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_eq;

  int checks = 0;
  int failures = 0;
  logic dp_hold = 1'b0;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .flush(flush), .busy(busy),
    .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_ctrl(dp_ctrl),
    .dp_result(dp_result), .dp_eq(dp_eq), .dp_stall(dp_stall),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_eq(alu_eq)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c);
    case (c)
      4'd0:    return x + y;
      4'd1:    return x - y;
      default: return x ^ y;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op1, alu_op2, alu_ctrl);
  assign alu_eq     = (alu_op1 == alu_op2);

  function automatic int lat_of(input logic [W-1:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int h = 0;
    for (int i = 0; i < W; i++) if (b[i]) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    return W;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // behavioural model: phase 0 idle, 1 multiplying, 2 result held
  int           m_phase = 0;
  int           m_left = 0;
  int           m_k = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_k = 0;
      m_a = '0; m_b = '0; m_prod = '0;
    end else begin
      case (m_phase)
        0: if (in_valid && !flush) begin
          m_a = in_a; m_b = in_b; m_prod = in_a * in_b;
          m_left = lat_of(in_b); m_k = 0; m_phase = 1;
        end
        1: if (flush) m_phase = 0;
           else begin
             m_k++; m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (flush || out_ready) m_phase = 0;
      endcase
    end
  end

  // datapath operands wander while the sequencer is idle
  always @(posedge clk) begin
    #3;
    if (!dp_hold) begin
      dp_op1 = $urandom;
      dp_op2 = ($urandom_range(0, 3) == 0) ? dp_op1 : $urandom;
      dp_ctrl = 4'($urandom_range(0, 3));
    end
  end

  logic [63:0]  e_msk;
  logic [W-1:0] e_op1;
  logic [W-1:0] e_op2;

  // compare every cycle against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("dp_stall", dp_stall, m_phase != 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("out_result", out_result, (m_phase == 2) ? m_prod : '0);
      if (m_phase == 0) begin
        chk("pt_op1", alu_op1, dp_op1);
        chk("pt_op2", alu_op2, dp_op2);
        chk("pt_ctrl", alu_ctrl, dp_ctrl);
        chk("pt_result", dp_result, alu_f(dp_op1, dp_op2, dp_ctrl));
        chk("pt_eq", dp_eq, dp_op1 == dp_op2);
      end else begin
        if (m_phase == 1) begin
          e_msk = (64'd1 << m_k) - 64'd1;
          e_op1 = m_a * (m_b & e_msk[W-1:0]);
          e_op2 = m_b[m_k] ? (m_a << m_k) : '0;
        end else begin
          e_op1 = m_prod;
          e_op2 = '0;
        end
        chk("own_ctrl", alu_ctrl, 4'b0000);
        chk("own_op1", alu_op1, e_op1);
        chk("own_op2", alu_op2, e_op2);
        chk("own_result", dp_result, '0);
        chk("own_eq", dp_eq, 1'b0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (!out_valid) chk("valid_timeout", out_valid, 1'b1);
  endtask

  task automatic mul_check(input string nm, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int lat,
                           input logic [W-1:0] res);
    int n;
    out_ready = 1'b0;
    start(a, b);
    wait_valid(n);
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_res"}, out_result, res);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;

    step(2);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dp_stall", dp_stall, 1'b0);
    rst_n = 1'b1;
    step();

    dp_hold = 1'b1;
    dp_ctrl = 4'b0001; dp_op1 = 5; dp_op2 = 5;
    #1;
    chk("lit_pt_ctrl", alu_ctrl, 4'b0001);
    chk("lit_pt_op1", alu_op1, 32'd5);
    chk("lit_pt_eq", dp_eq, 1'b1);
    chk("lit_pt_result", dp_result, 32'd0);
    dp_hold = 1'b0;
    step();

`ifdef ALU_MUL_EARLY_EXIT_EN
    mul_check("basic", 32'd7, 32'd6, 3, 32'd42);
    mul_check("mixed", 32'h8000_0000, 32'd2, 2, 32'd0);
    mul_check("ee_3x2", 32'd3, 32'd2, 2, 32'd6);
    mul_check("ee_9x0", 32'd9, 32'd0, 1, 32'd0);
`else
    mul_check("basic", 32'd7, 32'd6, 32, 32'd42);
    mul_check("mixed", 32'h8000_0000, 32'd2, 32, 32'd0);
    mul_check("x_3x2", 32'd3, 32'd2, 32, 32'd6);
    mul_check("x_9x0", 32'd9, 32'd0, 32, 32'd0);
`endif
    mul_check("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'd1);

    out_ready = 1'b0;
    start(32'd7, 32'd6);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; in_a = 1; in_b = 1;
      step();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_res", out_result, 32'd42);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_exit", out_valid, 1'b0);
    step();
    chk("bp_no_accept", busy, 1'b0);

    start(32'h1234_5678, 32'hFFFF_FFFF);
    step(9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);

    in_valid = 1'b1; flush = 1'b1; in_a = 3; in_b = 3;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_blocks", busy, 1'b0);

    start(32'd5, 32'd5);
    step(5);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_dp_stall", dp_stall, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    mul_check("post_rst", 32'd3, 32'd5, lat_of(32'd5), 32'd15);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      p = a * b;
      out_ready = 1'b0;
      start(a, b);
      if ($urandom_range(0, 5) == 0) begin
        step($urandom_range(0, 40));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("rnd_flush", busy, 1'b0);
      end else begin
        wait_valid(n);
        chk("rnd_lat", n, lat_of(b));
        chk("rnd_res", out_result, p);
        step($urandom_range(0, 3));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
      end
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-and-add multiplier sequencer that owns the shared 32-bit combinational ALU while a multiply is in flight.
- Computes the low Data_Width bits of a*b by driving the ALU add operation (ALU_ctrl 4'b0000) once per multiplier bit.
- When idle, passes the main datapath's ALU operands, control and results straight through.
- When busy, raises dp_stall so the core holds its pipeline.

Parameters:
- Data_Width, 32, operand/result width; also the number of RUN iterations.
- Cnt_Width, $clog2(Data_Width), iteration counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  multiply request valid.
- in_ready  output  1  sequencer can accept a request.
- in_a  input  Data_Width  multiplicand.
- in_b  input  Data_Width  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_result  output  Data_Width  low Data_Width bits of in_a*in_b.
- flush  input  1  synchronous abort.
- busy  output  1  multiply in progress (RUN or DONE).
- dp_op1  input  Data_Width  datapath ALU op1.
- dp_op2  input  Data_Width  datapath ALU op2.
- dp_ctrl  input  4  datapath ALU control.
- dp_result  output  Data_Width  ALU result returned to datapath.
- dp_eq  output  1  ALU eq flag returned to datapath.
- dp_stall  output  1  datapath must hold; ALU is owned by the sequencer.
- alu_op1  output  Data_Width  to ALU op1.
- alu_op2  output  Data_Width  to ALU op2.
- alu_ctrl  output  4  to ALU ALU_ctrl.
- alu_result  input  Data_Width  from ALU ALUout.
- alu_eq  input  1  from ALU eq.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- rst_n low clears everything immediately, independent of clk:
  - state=IDLE; acc, mcand, mplier and cnt = 0.
  - Outputs: in_ready=1, out_valid=0, out_result=0, busy=0, dp_stall=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; busy=0; dp_stall=0.
  - ALU mux passes through: alu_op1=dp_op1, alu_op2=dp_op2, alu_ctrl=dp_ctrl, dp_result=alu_result, dp_eq=alu_eq.
  - When in_valid is high at a clock edge: mcand<=in_a, mplier<=in_b, acc<=0, cnt<=0, go to RUN.
- RUN:
  - in_ready=0; busy=1; dp_stall=1; dp_result=0; dp_eq=0.
  - ALU drive: alu_ctrl=4'b0000, alu_op1=acc, alu_op2 = mplier[0] ? mcand : 0.
  - Each edge: acc<=alu_result; mcand<=mcand<<1 (zero fill); mplier<=mplier>>1 (logical); cnt<=cnt+1.
  - All arithmetic is modulo 2^Data_Width; the carry out of bit Data_Width-1 is discarded.
  - When cnt==Data_Width-1, go to DONE.
  - Latency: out_valid rises exactly Data_Width edges after the accepting edge (32 for the default).
- DONE:
  - out_valid=1; out_result=acc; busy=1; dp_stall=1; in_ready=0.
  - ALU mux behaves as in RUN, with alu_op2=0.
  - acc is held stable while out_ready=0.
  - When out_ready is high at an edge, go to IDLE; out_valid falls the following cycle.
  - in_valid is ignored until IDLE; there is no same-cycle accept on the return to IDLE.
- out_result is 0 whenever out_valid=0.
- flush high at an edge in RUN or DONE: go to IDLE and clear acc, mcand, mplier and cnt; the result is discarded.
- flush in IDLE has no effect; a simultaneous in_valid is not accepted.
- flush has priority over all other transitions.
- Reset mid-RUN: the result is discarded and the block restarts in IDLE once rst_n is released.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- With it defined:
  - In RUN, also go to DONE at an edge where the next mplier value (mplier>>1) is zero.
  - RUN always lasts at least one cycle, even for in_b=0.
  - Latency = max(1, index of the highest set bit of in_b + 1) edges.
- Without it: fixed latency of Data_Width edges; no zero-detect logic is present.

Test Plan:
- Basic multiply: accept in_a=7, in_b=6, out_ready=1.
  - out_valid rises exactly 32 edges later with out_result=42.
  - dp_stall=1 throughout RUN and DONE.
- Overflow wrap: in_a=0xFFFFFFFF, in_b=0xFFFFFFFF -> out_result=0x00000001.
- Mixed operands: in_a=0x80000000, in_b=2 -> out_result=0x00000000.
- Backpressure: out_ready=0 for 5 cycles after DONE.
  - out_valid and out_result=42 stay stable; in_valid pulses are ignored.
  - out_ready=1 -> IDLE on the next edge.
- Pass-through and stall:
  - In IDLE, dp_ctrl=4'b0001, dp_op1=dp_op2=5 -> alu_* mirror the dp_* inputs; dp_eq=1 and dp_result=0 in the same cycle.
  - In RUN: dp_result=0, dp_eq=0, alu_ctrl=0.
- Abort paths:
  - flush asserted at RUN cycle 10 -> IDLE next edge, out_valid never rises.
  - rst_n pulled low mid-RUN -> busy=0 and in_ready=1 immediately, before the next clk edge.
- With ALU_MUL_EARLY_EXIT_EN: 3*2 -> out_valid after 2 edges, result 6; 9*0 -> out_valid after 1 edge, result 0.
